// File: rtl/seg_display_scanner.sv
// -----------------------------------------------------------------------------
// seg_display_scanner
//
// Multiplexed 7-segment scanner. It shows DATA_WIDTH/4 hex digits, one digit
// at a time. Each digit is driven for DRIVE_CYCLES clocks and is then followed
// by GAP_CYCLES all-off clocks, which suppresses ghosting between digits.
//
// A new value is captured into a pending register on any valueValid strobe.
// It is moved to the displayed value only at frame end, so a frame never
// shows a mix of two values. When the displayed value changes, the decimal
// point on digit 0 flashes for FLASH_FRAMES frames.
//
// Ports:
//   clock        - single clock, rising edge
//   isReset      - asynchronous, active-low reset
//   value        - value to display
//   valueValid   - capture strobe for value
//   blank        - 1 forces the display dark; scanning keeps running
//   segments     - active-low {g,f,e,d,c,b,a}
//   digitEnable  - active-low digit select, bit 0 = least-significant nibble
//   decimalPoint - active-low decimal point
//   frameTick    - one-cycle pulse in the cycle after the frame-end edge
// -----------------------------------------------------------------------------
module seg_display_scanner #(
    parameter int DATA_WIDTH   = 8,
    parameter int DRIVE_CYCLES = 1000,
    parameter int GAP_CYCLES   = 16,
    parameter int FLASH_FRAMES = 8
) (
    input  logic                      clock,
    input  logic                      isReset,
    input  logic [DATA_WIDTH-1:0]     value,
    input  logic                      valueValid,
    input  logic                      blank,
    output logic [6:0]                segments,
    output logic [DATA_WIDTH/4-1:0]   digitEnable,
    output logic                      decimalPoint,
    output logic                      frameTick
);

    localparam int DIGITS  = DATA_WIDTH / 4;
    localparam int MAX_CYC = (DRIVE_CYCLES > GAP_CYCLES) ? DRIVE_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FLASH_W = $clog2(FLASH_FRAMES + 1);

    localparam logic [0:0] ST_DRIVE = 1'b0;
    localparam logic [0:0] ST_GAP   = 1'b1;

    localparam logic [CNT_W-1:0]   DRIVE_LAST = CNT_W'(DRIVE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(DIGITS - 1);
    localparam logic [FLASH_W-1:0] FLASH_LOAD = FLASH_W'(FLASH_FRAMES);

    // Scan and data state
    logic [0:0]            state_reg, state_next;
    logic [IDX_W-1:0]      idx_reg, idx_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [DATA_WIDTH-1:0] shown_reg, shown_next;
    logic [DATA_WIDTH-1:0] pending_reg, pending_next;
    logic                  pending_flag_reg, pending_flag_next;
    logic [FLASH_W-1:0]    flash_count_reg, flash_count_next;

    // Output registers
    logic [6:0]            segments_reg, segments_next;
    logic [DIGITS-1:0]     digit_enable_reg, digit_enable_next;
    logic                  decimal_point_reg, decimal_point_next;
    logic                  frame_tick_reg;

    logic                  frame_end;
    logic                  drive_on;
    logic [3:0]            nib [DIGITS];

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    // Scan FSM and value pipeline
    always_comb begin
        state_next        = state_reg;
        idx_next          = idx_reg;
        cnt_next          = cnt_reg + 1'b1;
        shown_next        = shown_reg;
        pending_next      = pending_reg;
        pending_flag_next = pending_flag_reg;
        flash_count_next  = flash_count_reg;

        frame_end = (state_reg == ST_GAP) && (idx_reg == IDX_LAST) && (cnt_reg == GAP_LAST);

        case (state_reg)
            ST_DRIVE: begin
                if (cnt_reg == DRIVE_LAST) begin
                    state_next = ST_GAP;
                    cnt_next   = '0;
                end
            end
            default: begin
                if (cnt_reg == GAP_LAST) begin
                    state_next = ST_DRIVE;
                    cnt_next   = '0;
                    idx_next   = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
                end
            end
        endcase

        if (frame_end) begin
            if (pending_flag_reg) begin
                shown_next        = pending_reg;
                pending_flag_next = 1'b0;
            end
            if (pending_flag_reg && (pending_reg != shown_reg)) begin
                flash_count_next = FLASH_LOAD;
            end else if (flash_count_reg != '0) begin
                flash_count_next = flash_count_reg - 1'b1;
            end
        end

        // A strobe on the frame-end edge refills pending after the old
        // pending has been moved to shown above, so the flag stays set.
        if (valueValid) begin
            pending_next      = value;
            pending_flag_next = 1'b1;
        end
    end

    // Outputs decode the next state so they line up with the state registers.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign nib[gi] = shown_next[4*gi +: 4];
            assign digit_enable_next[gi] = !(drive_on && (idx_next == IDX_W'(gi)));
        end
    endgenerate

    always_comb begin
        drive_on           = (state_next == ST_DRIVE) && !blank;
        segments_next      = drive_on ? hex7(nib[idx_next]) : 7'h7F;
        decimal_point_next = !(drive_on && (idx_next == '0) && (flash_count_next != '0));
    end

    always_ff @(posedge clock or negedge isReset) begin
        if (!isReset) begin
            state_reg         <= ST_DRIVE;
            idx_reg           <= '0;
            cnt_reg           <= '0;
            shown_reg         <= '0;
            pending_reg       <= '0;
            pending_flag_reg  <= 1'b0;
            flash_count_reg   <= '0;
            segments_reg      <= 7'h7F;
            digit_enable_reg  <= '1;
            decimal_point_reg <= 1'b1;
            frame_tick_reg    <= 1'b0;
        end else begin
            state_reg         <= state_next;
            idx_reg           <= idx_next;
            cnt_reg           <= cnt_next;
            shown_reg         <= shown_next;
            pending_reg       <= pending_next;
            pending_flag_reg  <= pending_flag_next;
            flash_count_reg   <= flash_count_next;
            segments_reg      <= segments_next;
            digit_enable_reg  <= digit_enable_next;
            decimal_point_reg <= decimal_point_next;
            frame_tick_reg    <= frame_end;
        end
    end

    assign segments     = segments_reg;
    assign digitEnable  = digit_enable_reg;
    assign decimalPoint = decimal_point_reg;
    assign frameTick    = frame_tick_reg;

endmodule

// File: tb/tb_seg_display_scanner.sv
// -----------------------------------------------------------------------------
// tb_seg_display_scanner
//
// Directed bench for seg_display_scanner with DATA_WIDTH=8, DRIVE_CYCLES=4,
// GAP_CYCLES=2, FLASH_FRAMES=2 (12-clock frame). Edge k counts rising edges
// since reset release; the outputs after edge k show frame position k mod 12:
//   0-3 digit 0 driven, 4-5 gap, 6-9 digit 1 driven, 10-11 gap,
// and frameTick is high at position 0 (k > 0).
// -----------------------------------------------------------------------------
module tb_seg_display_scanner;

    logic       clock;
    logic       isReset;
    logic [7:0] value;
    logic       valueValid;
    logic       blank;
    logic [6:0] segments;
    logic [1:0] digitEnable;
    logic       decimalPoint;
    logic       frameTick;

    int total = 0;
    int bad   = 0;
    int k     = 0;

    seg_display_scanner #(
        .DATA_WIDTH  (8),
        .DRIVE_CYCLES(4),
        .GAP_CYCLES  (2),
        .FLASH_FRAMES(2)
    ) dut (
        .clock       (clock),
        .isReset     (isReset),
        .value       (value),
        .valueValid  (valueValid),
        .blank       (blank),
        .segments    (segments),
        .digitEnable (digitEnable),
        .decimalPoint(decimalPoint),
        .frameTick   (frameTick)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic       vv;
        logic [7:0] val;
        logic       blk;
        logic [6:0] seg;
        logic [1:0] de;
        logic       dp;
        logic       ft;
    } vec_t;

    vec_t vecs [24];

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic chk_all(input string tag, input logic [6:0] s, input logic [1:0] d,
                           input logic p, input logic f);
        chk($sformatf("%s seg", tag), {1'b0, segments}, {1'b0, s});
        chk($sformatf("%s de", tag), {6'd0, digitEnable}, {6'd0, d});
        chk($sformatf("%s dp", tag), {7'd0, decimalPoint}, {7'd0, p});
        chk($sformatf("%s ft", tag), {7'd0, frameTick}, {7'd0, f});
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        k++;
    endtask

    // Step n edges; s0/s1 are the expected digit patterns, dp_on says whether
    // the decimal point flashes in this stretch, dark expects blanked outputs.
    task automatic scan(input int n, input logic [6:0] s0, input logic [6:0] s1,
                        input logic dp_on, input logic dark, input string tag);
        int         pos;
        logic [6:0] es;
        logic [1:0] ed;
        logic       ep;
        for (int i = 0; i < n; i++) begin
            step();
            pos = k % 12;
            es  = 7'h7F;
            ed  = 2'b11;
            ep  = 1'b1;
            if (!dark && pos <= 3) begin
                es = s0;
                ed = 2'b10;
                ep = !dp_on;
            end else if (!dark && pos >= 6 && pos <= 9) begin
                es = s1;
                ed = 2'b01;
            end
            chk_all($sformatf("%s k%0d", tag, k), es, ed, ep, pos == 0);
            $display("%s k=%0d pos=%0d seg=%h de=%b dp=%b ft=%b", tag, k, pos,
                     segments, digitEnable, decimalPoint, frameTick);
        end
    endtask

    initial begin
        // Reset release + A5 captured mid-frame; shown from k12, flash 2 frames.
        vecs[0]  = '{1'b0, 8'h00, 1'b0, 7'h40, 2'b10, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 8'h00, 1'b0, 7'h40, 2'b10, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 8'h00, 1'b0, 7'h40, 2'b10, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 8'h00, 1'b0, 7'h7F, 2'b11, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 8'hA5, 1'b0, 7'h7F, 2'b11, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 8'h00, 1'b0, 7'h40, 2'b01, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 8'h00, 1'b0, 7'h40, 2'b01, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 8'h00, 1'b0, 7'h40, 2'b01, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 8'h00, 1'b0, 7'h40, 2'b01, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 7'h7F, 2'b11, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 7'h7F, 2'b11, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 8'h00, 1'b0, 7'h12, 2'b10, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 8'h00, 1'b0, 7'h12, 2'b10, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 8'h00, 1'b0, 7'h12, 2'b10, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 8'h00, 1'b0, 7'h12, 2'b10, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 8'h00, 1'b0, 7'h7F, 2'b11, 1'b1, 1'b0};
        vecs[16] = '{1'b0, 8'h00, 1'b0, 7'h7F, 2'b11, 1'b1, 1'b0};
        vecs[17] = '{1'b0, 8'h00, 1'b0, 7'h08, 2'b01, 1'b1, 1'b0};
        vecs[18] = '{1'b0, 8'h00, 1'b0, 7'h08, 2'b01, 1'b1, 1'b0};
        vecs[19] = '{1'b0, 8'h00, 1'b0, 7'h08, 2'b01, 1'b1, 1'b0};
        vecs[20] = '{1'b0, 8'h00, 1'b0, 7'h08, 2'b01, 1'b1, 1'b0};
        vecs[21] = '{1'b0, 8'h00, 1'b0, 7'h7F, 2'b11, 1'b1, 1'b0};
        vecs[22] = '{1'b0, 8'h00, 1'b0, 7'h7F, 2'b11, 1'b1, 1'b0};
        vecs[23] = '{1'b0, 8'h00, 1'b0, 7'h12, 2'b10, 1'b0, 1'b1};

        isReset    = 1'b0;
        value      = 8'h00;
        valueValid = 1'b0;
        blank      = 1'b0;

        @(posedge clock);
        @(posedge clock);
        #1;
        chk_all("reset", 7'h7F, 2'b11, 1'b1, 1'b0);
        $display("reset seg=%h de=%b dp=%b ft=%b", segments, digitEnable, decimalPoint, frameTick);
        isReset = 1'b1;
        k = 0;

        for (int i = 0; i < 24; i++) begin
            valueValid = vecs[i].vv;
            value      = vecs[i].val;
            blank      = vecs[i].blk;
            step();
            chk_all($sformatf("vec k%0d", k), vecs[i].seg, vecs[i].de, vecs[i].dp, vecs[i].ft);
            $display("vec k=%0d seg=%h de=%b dp=%b ft=%b", k, segments, digitEnable,
                     decimalPoint, frameTick);
        end
        valueValid = 1'b0;
        value      = 8'h00;

        // Second flash frame of A5, then flash over.
        scan(11, 7'h12, 7'h08, 1'b1, 1'b0, "a5");
        scan(12, 7'h12, 7'h08, 1'b0, 1'b0, "a5_noflash");
        scan(1,  7'h12, 7'h08, 1'b0, 1'b0, "a5_noflash");

        // 3C then 7E in the same frame: only 7E is ever shown.
        valueValid = 1'b1; value = 8'h3C;
        scan(1, 7'h12, 7'h08, 1'b0, 1'b0, "wr3c");
        valueValid = 1'b0;
        scan(2, 7'h12, 7'h08, 1'b0, 1'b0, "wr3c");
        valueValid = 1'b1; value = 8'h7E;
        scan(1, 7'h12, 7'h08, 1'b0, 1'b0, "wr7e");
        valueValid = 1'b0;
        scan(7,  7'h12, 7'h08, 1'b0, 1'b0, "wr7e");
        scan(12, 7'h06, 7'h78, 1'b1, 1'b0, "show7e");
        scan(12, 7'h06, 7'h78, 1'b1, 1'b0, "show7e");
        scan(1,  7'h06, 7'h78, 1'b0, 1'b0, "show7e");

        // 22 pending, then 11 written on the frame-end edge.
        valueValid = 1'b1; value = 8'h22;
        scan(1, 7'h06, 7'h78, 1'b0, 1'b0, "wr22");
        valueValid = 1'b0;
        scan(10, 7'h06, 7'h78, 1'b0, 1'b0, "wr22");
        valueValid = 1'b1; value = 8'h11;
        scan(1, 7'h24, 7'h24, 1'b1, 1'b0, "fe11");
        valueValid = 1'b0;
        scan(11, 7'h24, 7'h24, 1'b1, 1'b0, "show22");
        scan(12, 7'h79, 7'h79, 1'b1, 1'b0, "show11");

        // Blank for 30 clocks; cadence continues, then scan resumes mid-frame.
        blank = 1'b1;
        scan(30, 7'h79, 7'h79, 1'b1, 1'b1, "blank");
        blank = 1'b0;
        scan(6,  7'h79, 7'h79, 1'b0, 1'b0, "unblank");
        scan(12, 7'h79, 7'h79, 1'b0, 1'b0, "unblank");

        // FF pending, then reset in the middle of digit 1 drive.
        valueValid = 1'b1; value = 8'hFF;
        scan(1, 7'h79, 7'h79, 1'b0, 1'b0, "wrff");
        valueValid = 1'b0;
        scan(6, 7'h79, 7'h79, 1'b0, 1'b0, "wrff");
        isReset = 1'b0;
        #1;
        chk_all("midrst", 7'h7F, 2'b11, 1'b1, 1'b0);
        $display("midrst seg=%h de=%b dp=%b ft=%b", segments, digitEnable, decimalPoint, frameTick);
        @(posedge clock);
        @(posedge clock);
        #1;
        chk_all("midrst_hold", 7'h7F, 2'b11, 1'b1, 1'b0);
        isReset = 1'b1;
        k = 0;
        scan(12, 7'h40, 7'h40, 1'b0, 1'b0, "postrst");
        scan(12, 7'h40, 7'h40, 1'b0, 1'b0, "postrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
